// File: rtl/reg_file.sv
// Multi-ported register file with write-to-read forwarding and a per-register
// pending-write scoreboard (lock on producer issue, clear on writeback).
module reg_file #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 16,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  input  logic             lock_en,
  input  logic [AW-1:0]    lock_addr,
  output logic             busy_a,
  output logic             busy_b,
  output logic [AW:0]      pend_cnt
);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] pend;
  logic [DEPTH-1:0] pend_nxt;
  logic [AW:0]      cnt_nxt;
  logic             fwd_a;
  logic             fwd_b;

  // NOTE: the storage array is reset like any other state because the
  // architecture requires every register to read 0 straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // NOTE: pend_nxt starts from the current value so no path leaves it
  // unassigned (no latch); the lock is applied last so a same-edge set wins.
  always_comb begin
    pend_nxt = pend;
    if (wr_en)   pend_nxt[wr_addr]   = 1'b0;
    if (lock_en) pend_nxt[lock_addr] = 1'b1;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) cnt_nxt = cnt_nxt + (AW+1)'(pend_nxt[i]);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend     <= '0;
      pend_cnt <= '0;
    end else begin
      pend     <= pend_nxt;
      pend_cnt <= cnt_nxt;
    end
  end

  // Forwarding is suppressed during reset so the ports read 0 unconditionally.
  assign fwd_a = (BYPASS != 0) && !rst && wr_en && (wr_addr == rd_addr_a);
  assign fwd_b = (BYPASS != 0) && !rst && wr_en && (wr_addr == rd_addr_b);

  assign rd_data_a = rst ? '0 : (fwd_a ? wr_data : regs[rd_addr_a]);
  assign rd_data_b = rst ? '0 : (fwd_b ? wr_data : regs[rd_addr_b]);

  // A forwarded write retires the hazard unless the same index is re-locked.
  assign busy_a = rst ? 1'b0 :
                  (fwd_a && !(lock_en && lock_addr == rd_addr_a)) ? 1'b0 : pend[rd_addr_a];
  assign busy_b = rst ? 1'b0 :
                  (fwd_b && !(lock_en && lock_addr == rd_addr_b)) ? 1'b0 : pend[rd_addr_b];

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: forwarding and non-forwarding builds share
// stimulus; a narrow WIDTH=8/DEPTH=4 build is exercised separately.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, lock_en;
  logic [3:0]  wr_addr, rd_addr_a, rd_addr_b, lock_addr;
  logic [31:0] wr_data;
  logic [31:0] rd_a0, rd_b0, rd_a1, rd_b1;
  logic        busy_a0, busy_b0, busy_a1, busy_b1;
  logic [4:0]  cnt0, cnt1;

  logic        s_wr_en, s_lock_en;
  logic [1:0]  s_wr_addr, s_rd_addr_a, s_rd_addr_b, s_lock_addr;
  logic [7:0]  s_wr_data, s_rd_a, s_rd_b;
  logic        s_busy_a, s_busy_b;
  logic [2:0]  s_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  reg_file #(.WIDTH(32), .DEPTH(16), .BYPASS(1)) dut_byp (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rd_a0), .rd_data_b(rd_b0),
    .lock_en(lock_en), .lock_addr(lock_addr), .busy_a(busy_a0), .busy_b(busy_b0),
    .pend_cnt(cnt0));

  reg_file #(.WIDTH(32), .DEPTH(16), .BYPASS(0)) dut_nobyp (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rd_a1), .rd_data_b(rd_b1),
    .lock_en(lock_en), .lock_addr(lock_addr), .busy_a(busy_a1), .busy_b(busy_b1),
    .pend_cnt(cnt1));

  reg_file #(.WIDTH(8), .DEPTH(4), .BYPASS(1)) dut_small (
    .clk(clk), .rst(rst), .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
    .rd_addr_a(s_rd_addr_a), .rd_addr_b(s_rd_addr_b), .rd_data_a(s_rd_a), .rd_data_b(s_rd_b),
    .lock_en(s_lock_en), .lock_addr(s_lock_addr), .busy_a(s_busy_a), .busy_b(s_busy_b),
    .pend_cnt(s_cnt));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    wr_en = 1'b0; lock_en = 1'b0; wr_addr = '0; lock_addr = '0; wr_data = '0;
    rd_addr_a = '0; rd_addr_b = '0;
    s_wr_en = 1'b0; s_lock_en = 1'b0; s_wr_addr = '0; s_lock_addr = '0; s_wr_data = '0;
    s_rd_addr_a = '0; s_rd_addr_b = '0;
    #2;
    check("por_rd_a", rd_a0, 0);
    check("por_cnt", cnt0, 0);
    check("por_busy", busy_a0, 0);
    tick();
    rst = 1'b0;
    tick();

    // Reset between edges wipes data and scoreboard immediately
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'hDEADBEEF;
    lock_en = 1'b1; lock_addr = 4'd3;
    tick();
    wr_en = 1'b0; lock_en = 1'b0; rd_addr_a = 4'd3;
    #1;
    check("pre_rst_rd", rd_a0, 32'hDEADBEEF);
    check("pre_rst_cnt", cnt0, 1);
    check("pre_rst_busy", busy_a0, 1);
    rst = 1'b1;
    #1;
    check("async_rst_rd", rd_a0, 0);
    check("async_rst_cnt", cnt0, 0);
    check("async_rst_busy", busy_a0, 0);
    wr_en = 1'b1; wr_data = 32'hFFFFFFFF; lock_en = 1'b1;
    #1;
    check("rst_no_fwd", rd_a0, 0);
    tick();
    wr_en = 1'b0; lock_en = 1'b0; rst = 1'b0;
    #1;
    check("rst_wr_ignored", rd_a0, 0);
    check("rst_lock_ignored", cnt0, 0);

    // Plain write then dual-port read
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'h12345678;
    tick();
    wr_en = 1'b0; rd_addr_a = 4'd5; rd_addr_b = 4'd5;
    #1;
    check("wr_rd_a", rd_a0, 32'h12345678);
    check("wr_rd_b", rd_b0, 32'h12345678);
    check("wr_rd_a_nobyp", rd_a1, 32'h12345678);
    rd_addr_b = 4'd6;
    #1;
    check("r6_zero", rd_b0, 0);

    // Same-cycle forwarding vs none
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'hA5A5A5A5; rd_addr_a = 4'd7; rd_addr_b = 4'd7;
    #1;
    check("byp_fwd_a", rd_a0, 32'hA5A5A5A5);
    check("byp_fwd_b", rd_b0, 32'hA5A5A5A5);
    check("nobyp_old", rd_a1, 0);
    tick();
    wr_en = 1'b0;
    #1;
    check("nobyp_after", rd_a1, 32'hA5A5A5A5);

    // Scoreboard lock / clear / relock
    lock_en = 1'b1; lock_addr = 4'd2;
    tick();
    lock_addr = 4'd4;
    tick();
    lock_en = 1'b0; rd_addr_a = 4'd2; rd_addr_b = 4'd4;
    #1;
    check("sb_cnt2", cnt0, 2);
    check("sb_busy2", busy_a0, 1);
    check("sb_busy4", busy_b0, 1);
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 32'h22;
    #1;
    check("sb_fwd_busy", busy_a0, 0);
    check("sb_nofwd_busy", busy_a1, 1);
    tick();
    wr_en = 1'b0;
    #1;
    check("sb_cnt1", cnt0, 1);
    check("sb_busy2_clr", busy_a1, 0);
    lock_en = 1'b1; lock_addr = 4'd4;
    tick();
    lock_en = 1'b0;
    #1;
    check("sb_relock_cnt", cnt0, 1);
    check("sb_relock_busy", busy_b0, 1);

    // Same-index lock and write: set wins, data still written
    lock_en = 1'b1; lock_addr = 4'd9;
    tick();
    lock_en = 1'b0;
    #1;
    check("col_cnt_pre", cnt0, 2);
    lock_en = 1'b1; lock_addr = 4'd9; wr_en = 1'b1; wr_addr = 4'd9; wr_data = 32'h1;
    rd_addr_a = 4'd9;
    #1;
    check("col_busy_same", busy_a0, 1);
    check("col_fwd", rd_a0, 1);
    tick();
    lock_en = 1'b0; wr_en = 1'b0;
    #1;
    check("col_data", rd_a1, 1);
    check("col_busy", busy_a0, 1);
    check("col_cnt", cnt0, 2);
    check("col_cnt_nobyp", cnt1, 2);

    // Different-index lock and write both take effect
    lock_en = 1'b1; lock_addr = 4'd10; wr_en = 1'b1; wr_addr = 4'd4; wr_data = 32'h44;
    tick();
    lock_en = 1'b0; wr_en = 1'b0; rd_addr_a = 4'd4; rd_addr_b = 4'd10;
    #1;
    check("diff_cnt", cnt0, 2);
    check("diff_busy4", busy_a0, 0);
    check("diff_busy10", busy_b0, 1);
    check("diff_data", rd_a0, 32'h44);

    // Narrow build: fill and drain the scoreboard
    for (int i = 0; i < 4; i++) begin
      s_lock_en = 1'b1; s_lock_addr = 2'(i);
      tick();
    end
    s_lock_en = 1'b0;
    #1;
    check("small_cnt_full", s_cnt, 4);
    for (int i = 0; i < 4; i++) begin
      s_wr_en = 1'b1; s_wr_addr = 2'(i); s_wr_data = 8'(8'h30 + i * 7);
      tick();
    end
    s_wr_en = 1'b0;
    #1;
    check("small_cnt_empty", s_cnt, 0);
    for (int i = 0; i < 4; i++) begin
      s_rd_addr_a = 2'(i); s_rd_addr_b = 2'(3 - i);
      #1;
      check("small_rd_a", s_rd_a, 64'(8'(8'h30 + i * 7)));
      check("small_rd_b", s_rd_b, 64'(8'(8'h30 + (3 - i) * 7)));
      check("small_busy_a", s_busy_a, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter WIDTH, default 32, data width of each register.
REQ-002 Parameter DEPTH, default 16, number of registers (power of two, >= 2); AW = clog2(DEPTH) is derived, not overridable.
REQ-003 Parameter BYPASS, default 1, 1 = same-cycle write data forwarded to read ports, 0 = no forwarding.
REQ-004 clk  input  1  rising-edge clock, sole clock.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 wr_en  input  1  write strobe.
REQ-007 wr_addr  input  AW  write register index.
REQ-008 wr_data  input  WIDTH  write data.
REQ-009 rd_addr_a / rd_addr_b  input  AW each  read indices, ports A and B.
REQ-010 rd_data_a / rd_data_b  output  WIDTH each  read data, ports A and B.
REQ-011 lock_en  input  1  marks a register as pending a future write (issue of a producer).
REQ-012 lock_addr  input  AW  register index to mark pending.
REQ-013 busy_a / busy_b  output  1 each  addressed register has a pending write.
REQ-014 pend_cnt  output  AW+1  number of registers currently pending.

Function
REQ-015 Storage: DEPTH x WIDTH registers, written only on rising clk when wr_en=1 and rst=0.
REQ-016 Reads are combinational; rd_data_x = reg[rd_addr_x] with zero-cycle latency.
REQ-017 BYPASS=1: if wr_en=1 and wr_addr==rd_addr_x, rd_data_x = wr_data in the same cycle; BYPASS=0: rd_data_x shows the old value until after the edge.
REQ-018 Both read ports operate independently and may address the same register, including wr_addr, simultaneously.
REQ-019 Scoreboard: one pending bit per register, updated on rising clk.
REQ-020 wr_en=1 clears pend[wr_addr]; lock_en=1 sets pend[lock_addr].
REQ-021 Same-edge lock_en and wr_en to the same index: set wins (new producer pending), data still written.
REQ-022 Same-edge lock_en and wr_en to different indices: both applied.
REQ-023 lock_en on an already pending register: bit stays 1, pend_cnt unchanged; wr_en on a non-pending register: write performed, bit stays 0.
REQ-024 busy_x = pend[rd_addr_x], except BYPASS=1 with wr_en=1, wr_addr==rd_addr_x and no same-cycle lock of that index: busy_x = 0.
REQ-025 pend_cnt = population count of pend bits, registered, consistent with pend after every edge, range 0..DEPTH, never wraps.
REQ-026 Out-of-range indices cannot occur (DEPTH power of two); no error handling.

Reset
REQ-027 rst=1 immediately, independent of clk, clears all registers to 0, all pend bits to 0 and pend_cnt to 0.
REQ-028 While rst=1, writes and locks are ignored; read ports show 0 (BYPASS forwarding still applies combinationally to wr_data only when rst=0).
REQ-029 Reset asserted mid-operation discards all pending state; first operation honoured is at the first rising clk after rst deasserts.

Verification
REQ-030 Reset: write 0xDEADBEEF to r3, assert rst between edges -> rd_data_a (addr 3) = 0 before next edge, pend_cnt = 0.
REQ-031 Write/read: wr_en, r5 <= 0x12345678; next cycle rd_addr_a=5, rd_addr_b=5 -> both read 0x12345678; r6 still 0.
REQ-032 Bypass: BYPASS=1, wr_en, wr_addr=7, wr_data=0xA5A5A5A5, rd_addr_a=7 same cycle -> rd_data_a = 0xA5A5A5A5 before edge; repeat with BYPASS=0 -> old value 0 until after edge.
REQ-033 Scoreboard: lock r2, lock r4 -> pend_cnt 2, busy on 2 and 4; write r2 -> pend_cnt 1, busy r2=0; relock r4 -> pend_cnt stays 1.
REQ-034 Collision: pending r9, same edge lock_en r9 and wr_en r9 = 0x1 -> r9 reads 0x1, busy r9 = 1, pend_cnt unchanged.
REQ-035 Parametrised build: WIDTH=8, DEPTH=4 -> lock all four, pend_cnt = 4 (3-bit output), write all -> pend_cnt = 0, data correct on both ports.
